// File: rtl/div_pipe_sched.sv
// div_pipe_sched
//   Shares one fixed-latency pipelined divider among N_REQ requesters.
//   A round-robin arbiter grants at most one request per cycle; the grant is
//   registered into a divider issue strobe. A DIV_LAT-deep tag pipe carries the
//   issuing requester ID so the divider result can be routed back. Per-requester
//   counters cap outstanding operations at MAX_OUT. Any disagreement between the
//   divider valid and the tag pipe tail raises a sticky seq_err.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/ready     per-requester handshake; req_ready is one-hot or zero
//   req_dividend/divisor packed operands, requester i at [i*DW +: DW]
//   div_start/dividend/divisor  registered issue to the divider
//   div_valid/quotient/by_zero  divider result
//   rsp_valid           one-hot, one-cycle result strobe
//   rsp_quotient/div_by_zero    shared result, held between strobes
//   busy                op issued, in flight, or response on the outputs
//   seq_err             sticky divider/tag misalignment flag
module div_pipe_sched #(
  parameter int N_REQ   = 4,
  parameter int DW      = 32,
  parameter int QW      = 8,
  parameter int DIV_LAT = 9,
  parameter int MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_dividend,
  input  logic [N_REQ*DW-1:0] req_divisor,
  output logic               div_start,
  output logic [DW-1:0]      div_dividend,
  output logic [DW-1:0]      div_divisor,
  input  logic               div_valid,
  input  logic [QW-1:0]      div_quotient,
  input  logic               div_by_zero,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [QW-1:0]      rsp_quotient,
  output logic               rsp_div_by_zero,
  output logic               busy,
  output logic               seq_err
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0]  MAX_CNT  = CW'(MAX_OUT);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(N_REQ - 1);

  // Arbitration state and issue registers
  logic [IDW-1:0]    rr_q, rr_d;
  logic [CW-1:0]     cnt_q [N_REQ];
  logic [CW-1:0]     cnt_d [N_REQ];
  logic              start_q;
  logic [IDW-1:0]    issue_id_q;
  logic [DW-1:0]     dvd_q, dvs_q;

  // Tag pipe and response registers
  logic [DIV_LAT-1:0] tag_v_q;
  logic [IDW-1:0]     tag_id_q [DIV_LAT];
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [QW-1:0]      rsp_quot_q;
  logic               rsp_dbz_q;
  logic               seq_err_q;

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  grant;
  logic              xfer;
  logic [IDW-1:0]    gnt_id;
  logic              tail_v;
  logic [IDW-1:0]    tail_id;
  logic [N_REQ-1:0]  dec_vec;
  logic [DW-1:0]     dvd_arr [N_REQ];
  logic [DW-1:0]     dvs_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign dvd_arr[g] = req_dividend[g*DW +: DW];
    assign dvs_arr[g] = req_divisor[g*DW +: DW];
  end

  assign tail_v  = tag_v_q[DIV_LAT-1];
  assign tail_id = tag_id_q[DIV_LAT-1];

  always_comb begin
    elig    = '0;
    dec_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i]    = req_valid[i] && (cnt_q[i] < MAX_CNT);
      dec_vec[i] = tail_v && (tail_id == IDW'(i));
    end
  end

  // Round-robin search starting at rr_q; first eligible index wins.
  always_comb begin
    int idx;
    idx    = 0;
    grant  = '0;
    gnt_id = '0;
    xfer   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!xfer && elig[idx[IDW-1:0]]) begin
        xfer                 = 1'b1;
        gnt_id               = idx[IDW-1:0];
        grant[idx[IDW-1:0]]  = 1'b1;
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    rr_d = rr_q;
    if (xfer) rr_d = (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);
  end

  // A tail exit frees its slot whether or not the divider answered, so a
  // missing result cannot permanently leak a requester's credit.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && !dec_vec[i]) begin
        if (cnt_q[i] != MAX_CNT) cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (!grant[i] && dec_vec[i]) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    if (div_valid && tail_v) rsp_valid_d[tail_id] = 1'b1;
  end

  // Stage boundary: arbitration -> divider issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      start_q    <= 1'b0;
      issue_id_q <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      rr_q    <= rr_d;
      start_q <= xfer;
      if (xfer) begin
        issue_id_q <= gnt_id;
        dvd_q      <= dvd_arr[gnt_id];
        dvs_q      <= dvs_arr[gnt_id];
      end
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Stage boundary: issue -> tag pipe (tail lines up with div_valid) -> response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_q     <= '0;
      for (int s = 0; s < DIV_LAT; s++) tag_id_q[s] <= '0;
      rsp_valid_q <= '0;
      rsp_quot_q  <= '0;
      rsp_dbz_q   <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      tag_v_q     <= {tag_v_q[DIV_LAT-2:0], start_q};
      tag_id_q[0] <= issue_id_q;
      for (int s = 1; s < DIV_LAT; s++) tag_id_q[s] <= tag_id_q[s-1];
      rsp_valid_q <= rsp_valid_d;
      if (div_valid && tail_v) begin
        rsp_quot_q <= div_quotient;
        rsp_dbz_q  <= div_by_zero;
      end
      if (div_valid != tail_v) seq_err_q <= 1'b1;
    end
  end

  assign div_start       = start_q;
  assign div_dividend    = dvd_q;
  assign div_divisor     = dvs_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_quotient    = rsp_quot_q;
  assign rsp_div_by_zero = rsp_dbz_q;
  assign seq_err         = seq_err_q;
  // The issue register counts as in flight: the op has left the requester
  // but has not yet entered the tag pipe.
  assign busy            = start_q || (|tag_v_q) || (|rsp_valid_q);

endmodule

// File: tb/tb_div_pipe_sched.sv
// Directed bench for div_pipe_sched with a behavioural 9-cycle divider model.
module tb_div_pipe_sched;

  localparam int N_REQ   = 4;
  localparam int DW      = 32;
  localparam int QW      = 8;
  localparam int DIV_LAT = 9;
  localparam int MAX_OUT = 4;

  logic               clk;
  logic               rst;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_dividend;
  logic [N_REQ*DW-1:0] req_divisor;
  logic               div_start;
  logic [DW-1:0]      div_dividend;
  logic [DW-1:0]      div_divisor;
  logic               div_valid;
  logic [QW-1:0]      div_quotient;
  logic               div_by_zero;
  logic [N_REQ-1:0]   rsp_valid;
  logic [QW-1:0]      rsp_quotient;
  logic               rsp_div_by_zero;
  logic               busy;
  logic               seq_err;

  int checks = 0;
  int errors = 0;

  div_pipe_sched #(
    .N_REQ(N_REQ), .DW(DW), .QW(QW), .DIV_LAT(DIV_LAT), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_valid(div_valid), .div_quotient(div_quotient), .div_by_zero(div_by_zero),
    .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_div_by_zero(rsp_div_by_zero),
    .busy(busy), .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: result DIV_LAT cycles after div_start; x/0 gives 0xFF + flag.
  logic [DIV_LAT-1:0] m_v;
  logic [QW-1:0]      m_q [DIV_LAT];
  logic               m_z [DIV_LAT];
  logic [DW-1:0]      m_full;
  logic [QW-1:0]      m_qin;
  logic               m_zin;
  logic               inject;

  always_comb begin
    m_full = '0;
    m_zin  = (div_divisor == '0);
    if (!m_zin) m_full = div_dividend / div_divisor;
    m_qin  = m_zin ? 8'hFF : m_full[QW-1:0];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v <= '0;
      for (int s = 0; s < DIV_LAT; s++) begin
        m_q[s] <= '0;
        m_z[s] <= 1'b0;
      end
    end else begin
      m_v    <= {m_v[DIV_LAT-2:0], div_start};
      m_q[0] <= m_qin;
      m_z[0] <= m_zin;
      for (int s = 1; s < DIV_LAT; s++) begin
        m_q[s] <= m_q[s-1];
        m_z[s] <= m_z[s-1];
      end
    end
  end

  assign div_valid    = m_v[DIV_LAT-1] | inject;
  assign div_quotient = m_q[DIV_LAT-1];
  assign div_by_zero  = m_z[DIV_LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_dividend[i*DW +: DW] = a;
    req_divisor[i*DW +: DW]  = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp4;
  logic [3:0] seen;
  logic [7:0] q_tab [4];

  initial begin
    q_tab[0] = 8'd20;  // 200/10
    q_tab[1] = 8'd10;  // 90/9
    q_tab[2] = 8'd11;  // 77/7
    q_tab[3] = 8'd77;  // 1000/3 = 333, low 8 bits
    rst = 1'b1; inject = 1'b0; req_valid = '0; req_dividend = '0; req_divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_start", div_start, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seqerr", seq_err, 0);
    chk("rst_dvd", div_dividend, 0);

    // Test 1: single op 100/7 from requester 0
    tick(); set_op(0, 100, 7); req_valid = 4'b0001; #1;
    chk("t1_ready", req_ready, 4'b0001);
    tick(); req_valid = '0; #1;
    chk("t1_start", div_start, 1);
    chk("t1_dvd", div_dividend, 100);
    chk("t1_dvs", div_divisor, 7);
    repeat (9) tick();
    #1;
    chk("t1_rsp_early", rsp_valid, 0);
    chk("t1_busy", busy, 1);
    tick(); #1;
    chk("t1_rsp", rsp_valid, 4'b0001);
    chk("t1_quot", rsp_quotient, 14);
    chk("t1_dbz", rsp_div_by_zero, 0);
    tick(); #1;
    chk("t1_rsp_off", rsp_valid, 0);
    chk("t1_quot_hold", rsp_quotient, 14);
    chk("t1_idle", busy, 0);

    // Test 2: all four held; pointer is at 1 after test 1
    set_op(0, 200, 10); set_op(1, 90, 9); set_op(2, 77, 7); set_op(3, 1000, 3);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) req_valid = 4'b1111;
      #1;
      exp4 = 4'b0001 << ((i + 1) % 4);
      chk("t2_grant", req_ready, exp4);
    end
    tick(); req_valid = '0;
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      #1;
      exp4 = 4'b0001 << ((i + 1) % 4);
      chk("t2_rsp", rsp_valid, exp4);
      chk("t2_quot", rsp_quotient, q_tab[(i + 1) % 4]);
    end
    tick(); #1;
    chk("t2_rsp_off", rsp_valid, 0);
    chk("t2_idle", busy, 0);

    // Test 3: only requester 1; cap of 4 outstanding
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k == 0) req_valid = 4'b0010;
      #1;
      exp4 = (k < 4 || k >= 11) ? 4'b0010 : 4'b0000;
      chk("t3_ready", req_ready, exp4);
      if (k == 10) chk("t3_rsp_none", rsp_valid, 0);
      if (k >= 11) chk("t3_rsp", rsp_valid, 4'b0010);
      if (k == 11) chk("t3_quot", rsp_quotient, 10);
    end
    tick(); req_valid = '0;
    repeat (20) tick();
    #1;
    chk("t3_idle", busy, 0);

    // Test 4: requester 2 divides by zero alongside requester 0
    tick(); set_op(2, 55, 0); set_op(0, 200, 10); req_valid = 4'b0101; #1;
    chk("t4_ready2", req_ready, 4'b0100);
    tick(); #1;
    chk("t4_ready0", req_ready, 4'b0001);
    chk("t4_start", div_start, 1);
    chk("t4_dvd", div_dividend, 55);
    chk("t4_dvs", div_divisor, 0);
    tick(); req_valid = '0; #1;
    chk("t4_dvd0", div_dividend, 200);
    chk("t4_dvs0", div_divisor, 10);
    repeat (9) tick();
    #1;
    chk("t4_rsp2", rsp_valid, 4'b0100);
    chk("t4_dbz2", rsp_div_by_zero, 1);
    chk("t4_quot2", rsp_quotient, 8'hFF);
    tick(); #1;
    chk("t4_rsp0", rsp_valid, 4'b0001);
    chk("t4_quot0", rsp_quotient, 20);
    chk("t4_dbz0", rsp_div_by_zero, 0);
    tick(); #1;
    chk("t4_rsp_off", rsp_valid, 0);
    chk("t4_idle", busy, 0);
    chk("t4_seqerr", seq_err, 0);

    // Test 5: spurious div_valid with an empty tag pipe
    tick(); inject = 1'b1;
    tick(); inject = 1'b0; #1;
    chk("t5_seqerr", seq_err, 1);
    chk("t5_no_rsp", rsp_valid, 0);
    repeat (3) tick();
    #1;
    chk("t5_sticky", seq_err, 1);
    chk("t5_no_rsp2", rsp_valid, 0);

    // Test 6: reset with three ops in flight; pointer is at 1
    tick(); set_op(0, 30, 3); set_op(1, 40, 4); set_op(2, 50, 5); req_valid = 4'b0111; #1;
    chk("t6_g1", req_ready, 4'b0010);
    tick(); #1;
    chk("t6_g2", req_ready, 4'b0100);
    tick(); #1;
    chk("t6_g0", req_ready, 4'b0001);
    tick(); req_valid = '0;
    tick();
    rst = 1'b1; #1;
    chk("t6_rst_start", div_start, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_seqerr", seq_err, 0);
    chk("t6_rst_dvd", div_dividend, 0);
    chk("t6_rst_quot", rsp_quotient, 0);
    tick(); tick(); rst = 1'b0;
    seen = '0;
    repeat (14) begin
      tick(); #1;
      seen = seen | rsp_valid;
    end
    chk("t6_no_rsp", seen, 0);
    chk("t6_seqerr", seq_err, 0);
    chk("t6_idle", busy, 0);
    tick(); set_op(3, 81, 9); req_valid = 4'b1000; #1;
    chk("t6_new_ready", req_ready, 4'b1000);
    tick(); req_valid = '0; #1;
    chk("t6_new_start", div_start, 1);
    chk("t6_new_dvd", div_dividend, 81);
    repeat (9) tick();
    #1;
    chk("t6_new_early", rsp_valid, 0);
    tick(); #1;
    chk("t6_new_rsp", rsp_valid, 4'b1000);
    chk("t6_new_quot", rsp_quotient, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
